pattern_scheduler: RTL and testbench

Frame-synchronous controller that owns the moving-pattern generators. It selects which generator is live and drives the one-hot `pattern_enable` bus. It sequences pattern changes from a dwell timer or a button, optionally with a blanked transition. It also owns the shared fixed-point `step_size` consumed by every generator. It sits between the button/input logic and the pattern generators, clocked in the pixel domain with `next_frame` from the VGA timing block.

---
 rtl/pattern_pkg.sv | 28 ++
 rtl/pattern_scheduler_frame_counter.sv | 34 +++
 rtl/pattern_scheduler.sv | 144 ++++++++++++++
 tb/tb_pattern_scheduler.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/pattern_pkg.sv
// Purpose     : shared constants for the pattern scheduler and its generators.
// Latency     : n/a (constants and types only).
// Backpressure: n/a.
// Contents: pattern index constants, generator count, step-size encodings
// (3-bit fixed point, [2] integer part, [1:0] quarters) and the FSM state encoding.
package pattern_pkg;

  localparam int NUM_PATTERNS = 4;

  // Pattern indices, one per generator
  localparam logic [1:0] PAT_CHECKER  = 2'd0;
  localparam logic [1:0] PAT_STRIPES  = 2'd1;
  localparam logic [1:0] PAT_BARS     = 2'd2;
  localparam logic [1:0] PAT_GRADIENT = 2'd3;

  // Step-size encodings (pixels per frame, in quarters)
  localparam logic [2:0] STEP_STOP    = 3'd0;
  localparam logic [2:0] STEP_QUARTER = 3'd1;
  localparam logic [2:0] STEP_HALF    = 3'd2;
  localparam logic [2:0] STEP_ONE     = 3'd4;
  localparam logic [2:0] STEP_MAX     = 3'd7;

  typedef enum logic {
    ST_SHOW  = 1'b0,
    ST_BLANK = 1'b1
  } state_e;

endpackage

// File: rtl/pattern_scheduler_frame_counter.sv
// Purpose     : next_frame-gated up-counter with clear and terminal-count flag.
// Latency     : count updates one clock after a next_frame cycle; tc is combinational from count.
// Backpressure: none; en/clr only act on next_frame cycles.
// Ports: clk, rst (sync, active-high), next_frame (gate), en (count up),
//        clr (return to zero, wins over en), tc (count == TERMINAL).
module frame_counter #(
  parameter int TERMINAL = 0,
  parameter int WIDTH    = (TERMINAL > 0) ? $clog2(TERMINAL + 1) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic next_frame,
  input  logic en,
  input  logic clr,
  output logic tc
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (next_frame) begin
      if (clr) begin
        count <= '0;
      end else if (en) begin
        count <= count + WIDTH'(1);
      end
    end
  end

  assign tc = (count == WIDTH'(TERMINAL));

endmodule

// File: rtl/pattern_scheduler.sv
// Purpose     : selects the live pattern generator, sequences changes (dwell timer / button), owns step_size.
// Latency     : outputs registered, change one clock after the triggering next_frame.
// Backpressure: none; button pulses are latched and serviced at the next frame boundary.
// Ports: clk, rst (sync, active-high), next_frame, btn_next, btn_speed, auto_en in;
//        pattern_sel, pattern_enable (one-hot, zero while blanked), step_size, blank, switch_done out.
// Build option: define PATTERN_SCHED_BLANK_EN to insert a BLANK_FRAMES-long blanked
// transition between patterns; without it a switch takes effect at the servicing frame.
module pattern_scheduler #(
  parameter int         NUM_PATTERNS = pattern_pkg::NUM_PATTERNS,
  parameter int         DWELL_FRAMES = 240,
  parameter int         BLANK_FRAMES = 4,
  parameter logic [2:0] STEP_RESET   = pattern_pkg::STEP_HALF
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            next_frame,
  input  logic                            btn_next,
  input  logic                            btn_speed,
  input  logic                            auto_en,
  output logic [$clog2(NUM_PATTERNS)-1:0] pattern_sel,
  output logic [NUM_PATTERNS-1:0]         pattern_enable,
  output logic [2:0]                      step_size,
  output logic                            blank,
  output logic                            switch_done
);

  import pattern_pkg::*;

  localparam int SEL_W = $clog2(NUM_PATTERNS);

  if (DWELL_FRAMES < 1) begin : g_bad_dwell
    $error("DWELL_FRAMES must be >= 1");
  end
  if (BLANK_FRAMES < 1) begin : g_bad_blank
    $error("BLANK_FRAMES must be >= 1");
  end

  function automatic logic [NUM_PATTERNS-1:0] to_onehot(input logic [SEL_W-1:0] s);
    to_onehot    = '0;
    to_onehot[s] = 1'b1;
  endfunction

  logic             switch_pend;
  logic [2:0]       speed_pend;
  logic             in_show;
  logic             dwell_tc;
  logic             service;
  logic [SEL_W-1:0] sel_next;

  assign sel_next = (pattern_sel == SEL_W'(NUM_PATTERNS - 1)) ? '0 : pattern_sel + SEL_W'(1);

  // Only the registered request counts, so a button pressed on a next_frame
  // cycle waits for the following frame; dwell expiry acts immediately.
  assign service = next_frame && in_show && (switch_pend || (auto_en && dwell_tc));

  // Dwell counter: counts shown frames, frozen while auto_en is low, restarted by every switch.
  frame_counter #(.TERMINAL(DWELL_FRAMES - 1)) u_dwell (
    .clk        (clk),
    .rst        (rst),
    .next_frame (next_frame),
    .en         (in_show && auto_en),
    .clr        (service),
    .tc         (dwell_tc)
  );

`ifdef PATTERN_SCHED_BLANK_EN
  state_e state;
  logic   blank_tc;

  assign in_show = (state == ST_SHOW);

  frame_counter #(.TERMINAL(BLANK_FRAMES - 1)) u_blank (
    .clk        (clk),
    .rst        (rst),
    .next_frame (next_frame),
    .en         (!in_show),
    .clr        (service || (!in_show && blank_tc)),
    .tc         (blank_tc)
  );
`else
  assign in_show = 1'b1;
  assign blank   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      pattern_sel    <= SEL_W'(PAT_CHECKER);
      pattern_enable <= to_onehot(SEL_W'(PAT_CHECKER));
      step_size      <= STEP_RESET;
      speed_pend     <= STEP_RESET;
      switch_pend    <= 1'b0;
      switch_done    <= 1'b0;
`ifdef PATTERN_SCHED_BLANK_EN
      state          <= ST_SHOW;
      blank          <= 1'b0;
`endif
    end else begin
      switch_done <= 1'b0;

      if (btn_speed) begin
        speed_pend <= speed_pend + 3'd1;
      end

      // A button arriving in the servicing cycle merges into that switch.
      if (service) begin
        switch_pend <= 1'b0;
      end else if (btn_next && in_show) begin
        switch_pend <= 1'b1;
      end

      if (next_frame) begin
        step_size <= speed_pend;
`ifdef PATTERN_SCHED_BLANK_EN
        case (state)
          ST_SHOW: begin
            if (service) begin
              state          <= ST_BLANK;
              blank          <= 1'b1;
              pattern_enable <= '0;
            end
          end
          ST_BLANK: begin
            if (blank_tc) begin
              state          <= ST_SHOW;
              blank          <= 1'b0;
              pattern_sel    <= sel_next;
              pattern_enable <= to_onehot(sel_next);
              switch_done    <= 1'b1;
            end
          end
          default: state <= ST_SHOW;
        endcase
`else
        if (service) begin
          pattern_sel    <= sel_next;
          pattern_enable <= to_onehot(sel_next);
          switch_done    <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Bench for pattern_scheduler with DWELL_FRAMES=3, BLANK_FRAMES=2.
// Expectations follow whichever build is compiled (PATTERN_SCHED_BLANK_EN defined or not).
module tb_pattern_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_frame;
  logic       btn_next;
  logic       btn_speed;
  logic       auto_en;
  logic [1:0] pattern_sel;
  logic [3:0] pattern_enable;
  logic [2:0] step_size;
  logic       blank;
  logic       switch_done;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pattern_scheduler #(
    .NUM_PATTERNS (4),
    .DWELL_FRAMES (3),
    .BLANK_FRAMES (2),
    .STEP_RESET   (3'd2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .next_frame     (next_frame),
    .btn_next       (btn_next),
    .btn_speed      (btn_speed),
    .auto_en        (auto_en),
    .pattern_sel    (pattern_sel),
    .pattern_enable (pattern_enable),
    .step_size      (step_size),
    .blank          (blank),
    .switch_done    (switch_done)
  );

  typedef struct {
    logic       nf;
    logic       bn;
    logic       bs;
    logic       au;
    logic [1:0] sel;
    logic [3:0] en;
    logic [2:0] step;
    logic       blk;
    logic       done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic nf, input logic bn, input logic bs, input logic au,
                              input logic [1:0] sel, input logic [3:0] en, input logic [2:0] step,
                              input logic blk, input logic done);
    vec_t v;
    v.nf = nf; v.bn = bn; v.bs = bs; v.au = au;
    v.sel = sel; v.en = en; v.step = step; v.blk = blk; v.done = done;
    return v;
  endfunction

  task automatic add(input logic nf, input logic bn, input logic bs, input logic au,
                     input logic [1:0] sel, input logic [3:0] en, input logic [2:0] step,
                     input logic blk, input logic done);
    vecs.push_back(mk(nf, bn, bs, au, sel, en, step, blk, done));
  endtask

  // Apply inputs for one clock, then settle just after the edge.
  task automatic drive(input logic nf, input logic bn, input logic bs, input logic au);
    @(negedge clk);
    next_frame = nf;
    btn_next   = bn;
    btn_speed  = bs;
    auto_en    = au;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input int idx, input vec_t e);
    n_vec++;
    if (pattern_sel !== e.sel || pattern_enable !== e.en || step_size !== e.step ||
        blank !== e.blk || switch_done !== e.done) begin
      n_bad++;
      $display("FAIL %s[%0d]: got sel=%0d en=%b step=%0d blank=%b done=%b, want sel=%0d en=%b step=%0d blank=%b done=%b",
               tag, idx, pattern_sel, pattern_enable, step_size, blank, switch_done,
               e.sel, e.en, e.step, e.blk, e.done);
    end
  endtask

  initial begin
    rst        = 1'b1;
    next_frame = 1'b0;
    btn_next   = 1'b0;
    btn_speed  = 1'b0;
    auto_en    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset", 0, mk(0, 0, 0, 0, 2'd0, 4'b0001, 3'd2, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    repeat (10) drive(0, 0, 0, 0);
    check("idle", 0, mk(0, 0, 0, 0, 2'd0, 4'b0001, 3'd2, 1'b0, 1'b0));

    //   nf bn bs au   sel   enable    step  blk done
`ifdef PATTERN_SCHED_BLANK_EN
    add(1, 0, 0, 1,  2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd0, 4'b0000, 3'd2, 1, 0);  // dwell expiry -> BLANK
    add(1, 0, 0, 1,  2'd0, 4'b0000, 3'd2, 1, 0);
    add(1, 0, 0, 1,  2'd1, 4'b0010, 3'd2, 0, 1);  // pattern 1 live
    add(0, 0, 0, 0,  2'd1, 4'b0010, 3'd2, 0, 0);
    add(0, 1, 0, 0,  2'd1, 4'b0010, 3'd2, 0, 0);  // mid-frame button
    add(0, 0, 0, 0,  2'd1, 4'b0010, 3'd2, 0, 0);
    add(1, 0, 0, 0,  2'd1, 4'b0000, 3'd2, 1, 0);
    add(0, 1, 0, 0,  2'd1, 4'b0000, 3'd2, 1, 0);  // ignored during BLANK
    add(1, 0, 0, 0,  2'd1, 4'b0000, 3'd2, 1, 0);
    add(1, 0, 0, 0,  2'd2, 4'b0100, 3'd2, 0, 1);
    add(1, 0, 0, 0,  2'd2, 4'b0100, 3'd2, 0, 0);  // no second switch
    add(1, 0, 0, 1,  2'd2, 4'b0100, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd2, 4'b0100, 3'd2, 0, 0);
    add(0, 1, 0, 1,  2'd2, 4'b0100, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd2, 4'b0000, 3'd2, 1, 0);  // button + expiry together
    add(1, 0, 0, 1,  2'd2, 4'b0000, 3'd2, 1, 0);
    add(1, 0, 0, 1,  2'd3, 4'b1000, 3'd2, 0, 1);
    add(1, 0, 0, 0,  2'd3, 4'b1000, 3'd2, 0, 0);  // only one switch
    add(0, 1, 0, 0,  2'd3, 4'b1000, 3'd2, 0, 0);
    add(1, 0, 0, 0,  2'd3, 4'b0000, 3'd2, 1, 0);
    add(1, 0, 0, 0,  2'd3, 4'b0000, 3'd2, 1, 0);
    add(1, 0, 0, 0,  2'd0, 4'b0001, 3'd2, 0, 1);  // wrap to 0
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 0,  2'd0, 4'b0001, 3'd0, 0, 0);  // 2+6 wraps to 0
    add(1, 0, 1, 0,  2'd0, 4'b0001, 3'd0, 0, 0);  // coincident: old value
    add(1, 0, 0, 0,  2'd0, 4'b0001, 3'd1, 0, 0);
`else
    add(1, 0, 0, 1,  2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd1, 4'b0010, 3'd2, 0, 1);  // dwell expiry
    add(0, 0, 0, 1,  2'd1, 4'b0010, 3'd2, 0, 0);
    add(0, 1, 0, 0,  2'd1, 4'b0010, 3'd2, 0, 0);  // mid-frame button
    add(0, 0, 0, 0,  2'd1, 4'b0010, 3'd2, 0, 0);
    add(1, 0, 0, 0,  2'd2, 4'b0100, 3'd2, 0, 1);
    add(1, 0, 0, 0,  2'd2, 4'b0100, 3'd2, 0, 0);
    add(1, 1, 0, 0,  2'd2, 4'b0100, 3'd2, 0, 0);  // button on next_frame waits
    add(1, 0, 0, 0,  2'd3, 4'b1000, 3'd2, 0, 1);
    add(1, 0, 0, 1,  2'd3, 4'b1000, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd3, 4'b1000, 3'd2, 0, 0);
    add(0, 1, 0, 1,  2'd3, 4'b1000, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd0, 4'b0001, 3'd2, 0, 1);  // button + expiry, wrap
    add(1, 0, 0, 0,  2'd0, 4'b0001, 3'd2, 0, 0);  // only one switch
    add(1, 0, 0, 1,  2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 0,  2'd0, 4'b0001, 3'd2, 0, 0);  // dwell holds
    add(1, 0, 0, 0,  2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd0, 4'b0001, 3'd2, 0, 0);
    add(1, 0, 0, 1,  2'd1, 4'b0010, 3'd2, 0, 1);
    for (int i = 0; i < 6; i++) add(0, 0, 1, 0, 2'd1, 4'b0010, 3'd2, 0, 0);
    add(1, 0, 0, 0,  2'd1, 4'b0010, 3'd0, 0, 0);  // 2+6 wraps to 0
    add(1, 0, 1, 0,  2'd1, 4'b0010, 3'd0, 0, 0);  // coincident: old value
    add(1, 0, 0, 0,  2'd1, 4'b0010, 3'd1, 0, 0);
`endif

    foreach (vecs[i]) begin
      drive(vecs[i].nf, vecs[i].bn, vecs[i].bs, vecs[i].au);
      check("vec", i, vecs[i]);
    end

    // Reset with a request pending (and, with blanking, mid-transition).
    drive(0, 1, 0, 0);
`ifdef PATTERN_SCHED_BLANK_EN
    drive(1, 0, 0, 0);
    check("pre_rst_blank", 0, mk(0, 0, 0, 0, 2'd0, 4'b0000, 3'd1, 1'b1, 1'b0));
`else
    drive(0, 0, 0, 0);
`endif
    @(negedge clk);
    next_frame = 1'b0;
    rst        = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst", 0, mk(0, 0, 0, 0, 2'd0, 4'b0001, 3'd2, 1'b0, 1'b0));
    @(negedge clk);
    rst = 1'b0;
    drive(1, 0, 0, 0);
    check("post_rst", 0, mk(0, 0, 0, 0, 2'd0, 4'b0001, 3'd2, 1'b0, 1'b0));
    drive(1, 0, 0, 0);
    check("post_rst", 1, mk(0, 0, 0, 0, 2'd0, 4'b0001, 3'd2, 1'b0, 1'b0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
